// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared constants for the round-robin 4:1 mux arbiter.
package mux4_rr_arbiter_pkg;

  localparam int N_REQ = 4;

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_GRANT = 1'b1;

endpackage

// File: rtl/mux4to1.sv
// Plain 4-to-1 single-bit multiplexer.
module mux4to1 (
  input  logic [3:0] a,
  input  logic [1:0] s,
  output logic       y
);

  // Select one data bit by index.
  always_comb begin
    y = a[s];
  end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning the select of a 4:1 mux, with a per-grant
// transfer cap applied only while other requesters are waiting.
module mux4_rr_arbiter
  import mux4_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] a,
  input  logic             out_ready,
  output logic             out_valid,
  output logic             y,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       sel
);

  localparam int CW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  logic             r_state, r_state_next;
  logic [1:0]       r_ptr, r_ptr_next;
  logic [1:0]       r_sel, r_sel_next;
  logic [N_REQ-1:0] r_gnt, r_gnt_next;
  logic [CW-1:0]    r_cnt, r_cnt_next;

  logic             w_mux_y;
  logic             w_valid;
  logic             w_xfer;
  logic             w_others;
  logic             w_release;
  logic [2:0]       w_pick_idle;
  logic [2:0]       w_pick_hand;

  // Returns {found, index}: first set bit of r scanning start, start+1, ... mod 4.
  function automatic logic [2:0] pick(input logic [N_REQ-1:0] r, input logic [1:0] start);
    logic [2:0] res;
    logic [1:0] idx;
    res = 3'b000;
    for (int k = 0; k < N_REQ; k++) begin
      idx = start + 2'(k);
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  mux4to1 u_mux (
    .a (a),
    .s (r_sel),
    .y (w_mux_y)
  );

  // Handshake and release decisions for the current grant.
  always_comb begin
    w_valid     = (r_state == ST_GRANT) && req[r_sel];
    w_xfer      = w_valid && out_ready;
    w_others    = |(req & ~r_gnt);
    w_release   = (r_state == ST_GRANT) &&
                  (!req[r_sel] || (w_xfer && (r_cnt == CNT_LAST) && w_others));
    w_pick_idle = pick(req, r_ptr);
    // Masking the current owner makes a handover always move to someone else.
    w_pick_hand = pick(req & ~r_gnt, r_sel + 2'd1);
  end

  // State register: all arbitration state, synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= 2'd0;
      r_sel   <= 2'd0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= r_state_next;
      r_ptr   <= r_ptr_next;
      r_sel   <= r_sel_next;
      r_gnt   <= r_gnt_next;
      r_cnt   <= r_cnt_next;
    end
  end

  // Next-state: grant from idle, hand over on release, count transfers otherwise.
  always_comb begin
    r_state_next = r_state;
    r_ptr_next   = r_ptr;
    r_sel_next   = r_sel;
    r_gnt_next   = r_gnt;
    r_cnt_next   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_pick_idle[2]) begin
          r_state_next = ST_GRANT;
          r_sel_next   = w_pick_idle[1:0];
          r_gnt_next   = N_REQ'(1) << w_pick_idle[1:0];
          r_cnt_next   = '0;
        end
      end
      default: begin
        if (w_release) begin
          r_ptr_next = r_sel + 2'd1;
          r_cnt_next = '0;
          if (w_pick_hand[2]) begin
            r_sel_next = w_pick_hand[1:0];
            r_gnt_next = N_REQ'(1) << w_pick_hand[1:0];
          end else begin
            r_state_next = ST_IDLE;
            r_gnt_next   = '0;
          end
        end else if (w_xfer) begin
          // With nobody else waiting the cap is irrelevant, so the count just wraps.
          if (r_cnt < CNT_LAST) r_cnt_next = r_cnt + 1'b1;
          else                  r_cnt_next = '0;
        end
      end
    endcase
  end

  // Outputs: valid and data follow the owner's request combinationally.
  always_comb begin
    out_valid = w_valid;
    y         = w_valid & w_mux_y;
    gnt       = r_gnt;
    sel       = r_sel;
  end

endmodule
